// File: rtl/mcdf_nch_pkt_engine_pkg.sv
// Shared constants for the N-channel packet engine: length codes, the
// length decode helper and the packet FSM state encoding.
package mcdf_nch_pkt_engine_pkg;

  localparam logic [7:0] MCDF_LEN4  = 8'd0;
  localparam logic [7:0] MCDF_LEN8  = 8'd1;
  localparam logic [7:0] MCDF_LEN16 = 8'd2;
  localparam logic [7:0] MCDF_LEN32 = 8'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SEND = 2'd2
  } state_t;

  // Unknown codes fall back to the longest packet.
  function automatic logic [5:0] decode_len(input logic [7:0] code);
    case (code)
      MCDF_LEN4:  decode_len = 6'd4;
      MCDF_LEN8:  decode_len = 6'd8;
      MCDF_LEN16: decode_len = 6'd16;
      default:    decode_len = 6'd32;
    endcase
  endfunction

endpackage

// File: rtl/mcdf_nch_pkt_engine_ch_fifo.sv
// Per-channel synchronous show-ahead FIFO with occupancy and free-space report.
// Ready is a register so it never depends combinationally on the pop.
module mcdf_ch_fifo #(
  parameter int DATA_W  = 32,
  parameter int FIFO_AW = 5
) (
  input  logic              clk,
  input  logic              srst,
  input  logic              en,
  input  logic              vld,
  input  logic [DATA_W-1:0] data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [FIFO_AW:0]  count,
  output logic [FIFO_AW:0]  margin,
  output logic              ready
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(DEPTH);

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]   count_reg, count_next;
  logic               ready_reg;
  logic               push, do_pop;

  assign push   = vld & ready_reg;
  assign do_pop = pop & (count_reg != '0);

  always_comb begin
    count_next = count_reg;
    if (push && !do_pop)
      count_next = count_reg + 1'b1;
    else if (!push && do_pop)
      count_next = count_reg - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= data;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      ready_reg <= en & (count_next != DEPTH_C);
    end
  end

  assign head   = mem[rd_ptr_reg];
  assign count  = count_reg;
  assign margin = DEPTH_C - count_reg;
  assign ready  = ready_reg;

endmodule

// File: rtl/mcdf_nch_pkt_engine.sv
// N-channel packet engine: per-channel FIFOs, priority/round-robin arbiter
// and a request/grant packet formatter driving the fmt_* interface.
module mcdf_nch_pkt_engine
  import mcdf_nch_pkt_engine_pkg::*;
#(
  parameter int CH_NUM  = 4,
  parameter int DATA_W  = 32,
  parameter int PRIO_W  = 2,
  parameter int LEN_W   = 3,
  parameter int FIFO_AW = 5,
  parameter int CHID_W  = $clog2(CH_NUM)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [CH_NUM*DATA_W-1:0]     ch_data_i,
  input  logic [CH_NUM-1:0]            ch_vld_i,
  output logic [CH_NUM-1:0]            ch_ready_o,
  input  logic [CH_NUM-1:0]            ch_en_i,
  input  logic [CH_NUM*PRIO_W-1:0]     ch_prio_i,
  input  logic [CH_NUM*LEN_W-1:0]      ch_pkglen_i,
  output logic [CH_NUM*(FIFO_AW+1)-1:0] ch_margin_o,
  output logic                         fmt_req_o,
  input  logic                         fmt_grant_i,
  output logic [CHID_W-1:0]            fmt_chid_o,
  output logic [5:0]                   fmt_length_o,
  output logic [DATA_W-1:0]            fmt_data_o,
  output logic                         fmt_start_o,
  output logic                         fmt_end_o
);

  localparam int CNT_W = FIFO_AW + 1;

  logic [DATA_W-1:0] head   [CH_NUM];
  logic [CNT_W-1:0]  count  [CH_NUM];
  logic [PRIO_W-1:0] prio   [CH_NUM];
  logic [LEN_W-1:0]  pkglen [CH_NUM];
  logic [CH_NUM-1:0] eligible, pop;

  state_t            state_reg, state_next;
  logic [CHID_W-1:0] chid_reg, rr_reg, win;
  logic [5:0]        len_reg, beat_reg;
  logic              any_elig;
  logic [PRIO_W-1:0] best;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_ch
      mcdf_ch_fifo #(.DATA_W(DATA_W), .FIFO_AW(FIFO_AW)) u_fifo (
        .clk    (clk_i),
        .srst   (rst_i),
        .en     (ch_en_i[gi]),
        .vld    (ch_vld_i[gi]),
        .data   (ch_data_i[gi*DATA_W +: DATA_W]),
        .pop    (pop[gi]),
        .head   (head[gi]),
        .count  (count[gi]),
        .margin (ch_margin_o[gi*CNT_W +: CNT_W]),
        .ready  (ch_ready_o[gi])
      );
      assign prio[gi]     = ch_prio_i[gi*PRIO_W +: PRIO_W];
      assign pkglen[gi]   = ch_pkglen_i[gi*LEN_W +: LEN_W];
      assign eligible[gi] = ch_en_i[gi] &
                            (count[gi] >= CNT_W'(decode_len(8'(pkglen[gi]))));
    end
  endgenerate

  // Scan from rr_reg so the first channel found wins among equal priorities.
  always_comb begin
    int idx;
    any_elig = 1'b0;
    best     = '1;
    win      = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      idx = int'(rr_reg) + i;
      if (idx >= CH_NUM)
        idx = idx - CH_NUM;
      if (eligible[idx] && (!any_elig || prio[idx] < best)) begin
        any_elig = 1'b1;
        best     = prio[idx];
        win      = CHID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (any_elig)            state_next = ST_REQ;
      ST_REQ:  if (fmt_grant_i)         state_next = ST_SEND;
      ST_SEND: if (beat_reg == len_reg) state_next = ST_IDLE;
      default:                          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chid_reg <= '0;
      len_reg  <= '0;
      beat_reg <= '0;
      rr_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (any_elig) begin
          chid_reg <= win;
          len_reg  <= decode_len(8'(pkglen[win]));
          rr_reg   <= (int'(win) == CH_NUM - 1) ? '0 : win + 1'b1;
        end
        ST_REQ:  if (fmt_grant_i) beat_reg <= 6'd1;
        ST_SEND: beat_reg <= beat_reg + 6'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    fmt_req_o    = 1'b0;
    fmt_chid_o   = '0;
    fmt_length_o = '0;
    fmt_data_o   = '0;
    fmt_start_o  = 1'b0;
    fmt_end_o    = 1'b0;
    pop          = '0;
    case (state_reg)
      ST_REQ: begin
        fmt_req_o    = 1'b1;
        fmt_chid_o   = chid_reg;
        fmt_length_o = len_reg;
      end
      ST_SEND: begin
        fmt_chid_o    = chid_reg;
        fmt_length_o  = len_reg;
        fmt_data_o    = head[chid_reg];
        fmt_start_o   = (beat_reg == 6'd1);
        fmt_end_o     = (beat_reg == len_reg);
        pop[chid_reg] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mcdf_nch_pkt_engine.sv
// Directed bench for mcdf_nch_pkt_engine: reset, single packet, priority,
// round-robin, full FIFO, config change in flight and reset mid-packet.
module tb_mcdf_nch_pkt_engine;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [127:0] ch_data_i;
  logic [3:0]   ch_vld_i;
  logic [3:0]   ch_ready_o;
  logic [3:0]   ch_en_i;
  logic [7:0]   ch_prio_i;
  logic [11:0]  ch_pkglen_i;
  logic [23:0]  ch_margin_o;
  logic         fmt_req_o;
  logic         fmt_grant_i;
  logic [1:0]   fmt_chid_o;
  logic [5:0]   fmt_length_o;
  logic [31:0]  fmt_data_o;
  logic         fmt_start_o;
  logic         fmt_end_o;

  int checks = 0;
  int errors = 0;

  mcdf_nch_pkt_engine dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .ch_data_i    (ch_data_i),
    .ch_vld_i     (ch_vld_i),
    .ch_ready_o   (ch_ready_o),
    .ch_en_i      (ch_en_i),
    .ch_prio_i    (ch_prio_i),
    .ch_pkglen_i  (ch_pkglen_i),
    .ch_margin_o  (ch_margin_o),
    .fmt_req_o    (fmt_req_o),
    .fmt_grant_i  (fmt_grant_i),
    .fmt_chid_o   (fmt_chid_o),
    .fmt_length_o (fmt_length_o),
    .fmt_data_o   (fmt_data_o),
    .fmt_start_o  (fmt_start_o),
    .fmt_end_o    (fmt_end_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [5:0] margin(input int ch);
    return ch_margin_o[ch*6 +: 6];
  endfunction

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
  endtask

  // Pushes n words to every channel in mask; channel k gets base + k*0x100 + i.
  task automatic push_words(input logic [3:0] mask, input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      for (int k = 0; k < 4; k++)
        ch_data_i[k*32 +: 32] = base + 32'(k) * 32'h100 + 32'(i);
      ch_vld_i = mask;
    end
    @(negedge clk_i);
    ch_vld_i = '0;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 200 && !fmt_req_o; i++)
      @(negedge clk_i);
    check("req_seen", fmt_req_o, 1);
  endtask

  // Waits for a request, grants it and checks every beat; optionally rewrites
  // all pkglen codes to 1 at beat index chg_beat.
  task automatic collect(input int chid, input int len, input logic [31:0] first,
                         input bit keep, input int chg_beat);
    wait_req();
    check("chid", fmt_chid_o, 64'(chid));
    check("length", fmt_length_o, 64'(len));
    fmt_grant_i = 1'b1;
    @(negedge clk_i);
    fmt_grant_i = keep;
    for (int b = 0; b < len; b++) begin
      check("data", fmt_data_o, 64'(first + 32'(b)));
      check("start", fmt_start_o, 64'(b == 0));
      check("end", fmt_end_o, 64'(b == len - 1));
      check("req_low_send", fmt_req_o, 0);
      if (b == chg_beat)
        ch_pkglen_i = 12'o1111;
      @(negedge clk_i);
    end
    $display("packet ch%0d len%0d first %0h done", chid, len, first);
  endtask

  initial begin
    bit seen;
    rst_i       = 1'b1;
    ch_data_i   = '0;
    ch_vld_i    = '0;
    ch_en_i     = 4'b0010;
    ch_prio_i   = '0;
    ch_pkglen_i = '0;
    fmt_grant_i = 1'b0;

    // 1. reset
    @(negedge clk_i);
    check("ready_in_reset", ch_ready_o, 0);
    @(negedge clk_i);
    check("ready_in_reset2", ch_ready_o, 0);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("ready_eq_en", ch_ready_o, 4'b0010);
    for (int k = 0; k < 4; k++)
      check("margin_reset", margin(k), 32);
    check("fmt_idle", {fmt_req_o, fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o}, 0);
    $display("reset done");

    // 2. single packet on ch1
    push_words(4'b0010, 32'hA000, 4);
    collect(1, 4, 32'hA100, 1'b0, -1);
    check("bubble_req", fmt_req_o, 0);
    check("margin_ch1_back", margin(1), 32);

    // 3. priority: ch2 (prio 0) beats ch0 (prio 2)
    ch_en_i   = 4'b0101;
    ch_prio_i = 8'b00_00_00_10;
    push_words(4'b0101, 32'hB000, 4);
    collect(2, 4, 32'hB200, 1'b0, -1);
    collect(0, 4, 32'hB000, 1'b0, -1);

    // 4. round robin from rr_ptr = 0 with grant held high
    do_reset();
    ch_en_i   = 4'b1111;
    ch_prio_i = 8'b01_01_01_01;
    push_words(4'b1111, 32'hC000, 8);
    collect(0, 4, 32'hC000, 1'b1, -1);
    collect(1, 4, 32'hC100, 1'b1, -1);
    collect(2, 4, 32'hC200, 1'b1, -1);
    collect(3, 4, 32'hC300, 1'b1, -1);
    collect(0, 4, 32'hC004, 1'b0, -1);

    // 5. full FIFO: 33rd word dropped, one 32-word packet drains it
    do_reset();
    ch_en_i     = 4'b0001;
    ch_prio_i   = '0;
    ch_pkglen_i = 12'o0003;
    push_words(4'b0001, 32'hD000, 33);
    check("ready_full", ch_ready_o[0], 0);
    check("margin_full", margin(0), 0);
    collect(0, 32, 32'hD000, 1'b0, -1);
    check("margin_drained", margin(0), 32);
    check("ready_back", ch_ready_o[0], 1);

    // 6a. pkglen change during SEND leaves the packet at 4 beats
    ch_pkglen_i = '0;
    push_words(4'b0001, 32'hE000, 8);
    collect(0, 4, 32'hE000, 1'b0, 1);
    seen = 1'b0;
    repeat (6) begin
      seen |= fmt_req_o;
      @(negedge clk_i);
    end
    check("no_req_short", seen, 0);
    check("margin_after_4", margin(0), 28);

    // 6b. reset on beat 3 of an 8-beat packet
    push_words(4'b0001, 32'hE008, 4);
    wait_req();
    check("length8", fmt_length_o, 8);
    fmt_grant_i = 1'b1;
    @(negedge clk_i);
    fmt_grant_i = 1'b0;
    for (int b = 0; b < 3; b++) begin
      check("abort_data", fmt_data_o, 64'(32'hE004 + 32'(b)));
      if (b < 2) @(negedge clk_i);
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    check("abort_fmt", {fmt_req_o, fmt_chid_o, fmt_length_o, fmt_data_o, fmt_start_o, fmt_end_o}, 0);
    check("abort_margin", margin(0), 32);
    check("abort_ready", ch_ready_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      seen |= fmt_end_o | fmt_req_o;
      @(negedge clk_i);
    end
    check("no_end_after_abort", seen, 0);
    check("ready_after_abort", ch_ready_o[0], 1);
    $display("abort done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
